ca_row_engine: RTL and testbench

- Parametrised one-dimensional cellular-automaton row generator.
- Holds a full N_CELLS-wide row and computes the whole next generation in one clock under a runtime-loadable rule.
- Supports selectable edge boundary handling, single-step and free-run modes, and a generation limit.
- Streams each generation to a downstream consumer (row writer feeding the VGA/SRAM path) over a valid/ready handshake.

---
 rtl/ca_row_engine.sv | 163 ++++++++++++++++
 tb/tb_ca_row_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ca_row_engine.sv
// One-dimensional cellular-automaton row engine: computes a full next generation per clock
// under a loadable rule and streams generations out over a valid/ready handshake.
module ca_row_engine #(
    parameter int N_CELLS      = 64,
    parameter int RADIUS       = 1,
    parameter int DEFAULT_RULE = 30,
    parameter int GEN_W        = 16,
    localparam int NB          = 2 * RADIUS + 1,
    localparam int W_RULE      = 2 ** NB
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [N_CELLS-1:0] i_seed,
    input  logic               i_rule_we,
    input  logic [W_RULE-1:0]  i_rule,
    input  logic [1:0]         i_boundary,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_step,
    input  logic [GEN_W-1:0]   i_gen_limit,
    input  logic               i_ready,
    output logic [N_CELLS-1:0] o_row,
    output logic               o_valid,
    output logic [GEN_W-1:0]   o_gen,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_CELLS-1:0]  r_row;
    logic [GEN_W-1:0]    r_gen;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic [W_RULE-1:0]   r_rule;
    logic [N_CELLS-1:0]  w_next;
    logic                w_adv;
    logic                w_valid_nxt;
    logic                w_limit_hit;
    logic                w_wrap;
    logic                w_const;

    // Reserved boundary code 11 behaves like constant 0.
    assign w_wrap      = (i_boundary == 2'b00);
    assign w_const     = (i_boundary == 2'b10);
    assign w_limit_hit = (i_gen_limit != {GEN_W{1'b0}}) && (r_gen == i_gen_limit);

    // Neighbourhood bit gk corresponds to cell gi+gk-RADIUS, so the highest cell lands in the MSB.
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        logic [NB-1:0] w_idx;
        for (genvar gk = 0; gk < NB; gk++) begin : g_nb
            localparam int J = gi + gk - RADIUS;
            if (J < 0) begin : g_lo
                assign w_idx[gk] = w_wrap ? r_row[J+N_CELLS] : w_const;
            end else if (J >= N_CELLS) begin : g_hi
                assign w_idx[gk] = w_wrap ? r_row[J-N_CELLS] : w_const;
            end else begin : g_in
                assign w_idx[gk] = r_row[J];
            end
        end
        assign w_next[gi] = r_rule[w_idx];
    end

    // Next-state and advance/valid decisions; load overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_valid_nxt = r_valid;
        if (i_load) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        w_state_nxt = ST_RUN;
                    end else if (i_step && !i_stop && !w_limit_hit) begin
                        w_adv       = 1'b1;
                        w_valid_nxt = 1'b1;
                    end else if (r_valid && i_ready) begin
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_valid_nxt = r_valid;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (!r_valid) begin
                        // Entering RUN with nothing on offer: present the current row first.
                        w_valid_nxt = 1'b1;
                    end else if (i_ready) begin
                        if (w_limit_hit) begin
                            w_state_nxt = ST_DONE;
                            w_valid_nxt = 1'b0;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end else begin
                        w_valid_nxt = r_valid;
                    end
                end
                ST_DONE: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row, generation, flags and rule registers; rule write is independent of the state machine.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row   <= {N_CELLS{1'b0}};
            r_gen   <= {GEN_W{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rule  <= W_RULE'(DEFAULT_RULE);
        end else begin
            if (i_rule_we) begin
                r_rule <= i_rule;
            end
            if (i_load) begin
                r_row <= i_seed;
                r_gen <= {GEN_W{1'b0}};
            end else if (w_adv) begin
                r_row <= w_next;
                r_gen <= r_gen + GEN_W'(1);
            end
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_row   = r_row;
    assign o_gen   = r_gen;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_ca_row_engine.sv
// Directed bench for ca_row_engine (N_CELLS=64, RADIUS=1, rule 30 default).
module tb_ca_row_engine;

    localparam int N = 64;
    localparam int G = 16;

    logic          clk;
    logic          rst;
    logic          load;
    logic [N-1:0]  seed;
    logic          rule_we;
    logic [7:0]    rule;
    logic [1:0]    boundary;
    logic          start;
    logic          stop;
    logic          step;
    logic [G-1:0]  gen_limit;
    logic          ready;
    logic [N-1:0]  row;
    logic          valid;
    logic [G-1:0]  gen;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [N-1:0] SEED32 = 64'h0000_0001_0000_0000;
    localparam logic [N-1:0] R30_G1 = 64'h0000_0003_8000_0000;
    localparam logic [N-1:0] R30_G2 = 64'h0000_0006_4000_0000;
    localparam logic [N-1:0] R30_G3 = 64'h0000_000D_E000_0000;
    localparam logic [N-1:0] R90_G2 = 64'h0000_0006_C000_0000;

    ca_row_engine #(.N_CELLS(N), .RADIUS(1), .DEFAULT_RULE(30), .GEN_W(G)) dut (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_seed(seed),
        .i_rule_we(rule_we), .i_rule(rule), .i_boundary(boundary),
        .i_start(start), .i_stop(stop), .i_step(step), .i_gen_limit(gen_limit),
        .i_ready(ready), .o_row(row), .o_valid(valid), .o_gen(gen),
        .o_busy(busy), .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [N-1:0] s);
        seed = s; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic write_rule(input logic [7:0] r);
        rule = r; rule_we = 1'b1;
        tick();
        rule_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; seed = '0; rule_we = 1'b0; rule = 8'd0;
        boundary = 2'b01; start = 1'b0; stop = 1'b0; step = 1'b0;
        gen_limit = 16'd0; ready = 1'b0;
        #2;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_row", row, 64'd0);
        chk("rst_gen", 64'(gen), 64'd0);
        chk("rst_flags", {61'd0, valid, busy, done}, 64'd0);

        // Rule 30 growth from a single cell.
        pulse_load(SEED32);
        chk("load_row", row, SEED32);
        chk("load_valid", 64'(valid), 64'd1);
        pulse_step();
        chk("r30_g1", row, R30_G1);
        chk("r30_g1_gen", 64'(gen), 64'd1);
        pulse_step();
        chk("r30_g2", row, R30_G2);
        chk("r30_g2_gen", 64'(gen), 64'd2);

        // Boundary modes with rule 170 (shift toward higher index).
        write_rule(8'd170);
        boundary = 2'b00;
        pulse_load(64'h8000_0000_0000_0000);
        pulse_step();
        chk("bnd_wrap", row, 64'd1);
        boundary = 2'b01;
        pulse_load(64'h8000_0000_0000_0000);
        pulse_step();
        chk("bnd_zero", row, 64'd0);
        boundary = 2'b10;
        pulse_load(64'd0);
        pulse_step();
        chk("bnd_one", row, 64'd1);
        boundary = 2'b11;
        pulse_load(64'h8000_0000_0000_0001);
        pulse_step();
        chk("bnd_rsvd", row, 64'd2);
        boundary = 2'b01;

        // Backpressure in RUN: ready pattern 1,0,0,1.
        write_rule(8'd30);
        pulse_load(SEED32);
        pulse_start();
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_gen0", 64'(gen), 64'd0);
        ready = 1'b1; tick();
        chk("bp_gen_a", 64'(gen), 64'd1);
        chk("bp_row_a", row, R30_G1);
        ready = 1'b0; tick();
        chk("bp_gen_b", 64'(gen), 64'd1);
        tick();
        chk("bp_row_c", row, R30_G1);
        chk("bp_valid_c", 64'(valid), 64'd1);
        ready = 1'b1; tick();
        chk("bp_gen_d", 64'(gen), 64'd2);
        chk("bp_row_d", row, R30_G2);
        ready = 1'b0;
        pulse_stop();
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_valid", 64'(valid), 64'd1);
        chk("stop_gen", 64'(gen), 64'd2);

        // Generation limit 3.
        gen_limit = 16'd3;
        pulse_load(SEED32);
        pulse_start();
        ready = 1'b1;
        tick(); tick(); tick();
        chk("lim_gen3", 64'(gen), 64'd3);
        chk("lim_valid3", 64'(valid), 64'd1);
        chk("lim_row3", row, R30_G3);
        tick();
        ready = 1'b0;
        chk("lim_done", 64'(done), 64'd1);
        chk("lim_valid", 64'(valid), 64'd0);
        chk("lim_busy", 64'(busy), 64'd0);
        chk("lim_gen", 64'(gen), 64'd3);
        pulse_step();
        pulse_start();
        chk("done_hold_gen", 64'(gen), 64'd3);
        chk("done_hold_row", row, R30_G3);
        chk("done_hold", 64'(done), 64'd1);
        pulse_load(SEED32);
        chk("done_exit", {61'd0, valid, busy, done}, 64'd4);
        chk("done_exit_gen", 64'(gen), 64'd0);
        gen_limit = 16'd0;

        // Rule swap on the same edge as an advance.
        pulse_start();
        ready = 1'b1; rule = 8'd90; rule_we = 1'b1;
        tick();
        rule_we = 1'b0;
        chk("swap_old", row, R30_G1);
        tick();
        ready = 1'b0;
        chk("swap_new", row, R90_G2);
        pulse_stop();

        // Load and step together: load wins.
        seed = 64'd5; load = 1'b1; step = 1'b1;
        tick();
        load = 1'b0; step = 1'b0;
        chk("ldstep_row", row, 64'd5);
        chk("ldstep_gen", 64'(gen), 64'd0);

        // Reset in the middle of a run.
        pulse_load(SEED32);
        pulse_start();
        ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ready = 1'b0;
        chk("mid_gen5", 64'(gen), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_row", row, 64'd0);
        chk("mid_rst_gen", 64'(gen), 64'd0);
        chk("mid_rst_flags", {61'd0, valid, busy, done}, 64'd0);
        pulse_load(SEED32);
        pulse_step();
        chk("mid_rst_rule", row, R30_G1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
